// File: rtl/i2c_byte_dri_pkg.sv
// i2c_pkg: shared definitions for the I2C byte driver.
//   state_t   : FSM state encoding
//   RW_WR/RD  : R/W bit appended to the 7-bit device address
//   ACK_SLOT  : bit index of the acknowledge bit inside a 9-bit byte slot
//   calc_div  : clk cycles per quarter SCL period
package i2c_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 4'd0,
    START   = 4'd1,
    CTRL_W  = 4'd2,
    ADDR_H  = 4'd3,
    ADDR_L  = 4'd4,
    DATA_W  = 4'd5,
    RESTART = 4'd6,
    CTRL_R  = 4'd7,
    DATA_R  = 4'd8,
    STOP    = 4'd9,
    DONE    = 4'd10
  } state_t;

  localparam logic RW_WR = 1'b0;
  localparam logic RW_RD = 1'b1;

  localparam logic [3:0] ACK_SLOT = 4'd8;

  function automatic int calc_div(input int clk_freq, input int i2c_freq);
    return clk_freq / (4 * i2c_freq);
  endfunction

endpackage

// File: rtl/i2c_byte_dri_if.sv
// i2c_byte_dri_if: request/response handshake with the EEPROM sequencer plus
// the SCL/SDA pad signals.
//   master : the requesting side (sequencer and pad logic)
//   slave  : the byte driver itself
interface i2c_byte_dri_if;

  logic        i2c_start_flag;
  logic        i2c_wr_flag;
  logic        i2c_rd_flag;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_wr;
  logic [7:0]  i2c_data_rd;
  logic        i2c_done;
  logic        i2c_ack;
  logic        scl;
  logic        sda_out;
  logic        sda_oe;
  logic        sda_in;

  modport master (
    output i2c_start_flag, i2c_wr_flag, i2c_rd_flag, i2c_addr, i2c_data_wr, sda_in,
    input  i2c_data_rd, i2c_done, i2c_ack, scl, sda_out, sda_oe
  );

  modport slave (
    input  i2c_start_flag, i2c_wr_flag, i2c_rd_flag, i2c_addr, i2c_data_wr, sda_in,
    output i2c_data_rd, i2c_done, i2c_ack, scl, sda_out, sda_oe
  );

endinterface

// File: rtl/i2c_byte_dri_tick_gen.sv
// i2c_tick_gen: quarter-SCL-period tick generator.
//   clk, rstn : system clock, async active-low reset
//   en        : run enable; while low the divider and phase are held at zero
//   tick      : one-cycle strobe every DIV clk cycles
//   phase     : quarter index (0..3) that the next tick belongs to
module i2c_tick_gen
  import i2c_pkg::*;
#(
  parameter int DIV = calc_div(50_000_000, 250_000)
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Divider and phase counter; phase advances on every tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      phase <= 2'd0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 2'd0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_byte_dri.sv
// i2c_byte_dri: bit-level I2C master doing one random-address EEPROM byte
// write or byte read per request.
//   clk, rstn : system clock, async active-low reset
//   bus       : slave modport of i2c_byte_dri_if
//               in : i2c_start_flag (rising edge launches), i2c_wr_flag,
//                    i2c_rd_flag, i2c_addr, i2c_data_wr, sda_in
//               out: i2c_data_rd, i2c_done (DONE_CYCLES long), i2c_ack (NACK
//                    seen), scl, sda_out, sda_oe
// Each SCL bit is four ticks: 0 change SDA, 1 SCL up, 2 sample, 3 SCL down.
module i2c_byte_dri
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'b1010000,
  parameter int         CLK_FREQ    = 50_000_000,
  parameter int         I2C_FREQ    = 250_000,
  parameter int         BIT_CTRL    = 1,
  parameter int         DONE_CYCLES = 50
) (
  input logic          clk,
  input logic          rstn,
  i2c_byte_dri_if.slave bus
);

  localparam int             DIV  = calc_div(CLK_FREQ, I2C_FREQ);
  localparam int             DCW  = $clog2(DONE_CYCLES + 1);
  localparam logic [DCW-1:0] DLST = DCW'(DONE_CYCLES - 1);

  state_t         state_q, state_d, slot_nxt;
  logic           scl_q, scl_d;
  logic           sda_out_q, sda_out_d;
  logic           sda_oe_q, sda_oe_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           ack_q, ack_d;
  logic           done_q, done_d;
  logic [DCW-1:0] done_cnt_q, done_cnt_d;
  logic [7:0]     data_rd_q, data_rd_d;
  logic [15:0]    addr_q, addr_d;
  logic [7:0]     wdata_q, wdata_d;
  logic           rw_q, rw_d;
  logic           start_d1;
  logic           start_rise;
  logic           tick;
  logic [1:0]     phase;
  logic           tick_en;
  logic           is_rx;

  assign start_rise = bus.i2c_start_flag && !start_d1;
  assign tick_en    = (state_q != IDLE) && (state_q != DONE);
  assign is_rx      = (state_q == DATA_R);

  i2c_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rstn  (rstn),
    .en    (tick_en),
    .tick  (tick),
    .phase (phase)
  );

  // Byte loaded into the shift register when a slot begins; non-slot
  // targets keep the current contents so read data survives into STOP.
  function automatic logic [7:0] slot_byte(input state_t s, input logic [15:0] a,
                                           input logic [7:0] d, input logic [7:0] hold);
    case (s)
      CTRL_W:  return {SLAVE_ADDR, RW_WR};
      ADDR_H:  return a[15:8];
      ADDR_L:  return a[7:0];
      DATA_W:  return d;
      CTRL_R:  return {SLAVE_ADDR, RW_RD};
      DATA_R:  return 8'h00;
      default: return hold;
    endcase
  endfunction

  // Slot that follows the current one when its ack bit completes cleanly.
  always_comb begin
    slot_nxt = STOP;
    case (state_q)
      CTRL_W:  slot_nxt = (BIT_CTRL != 0) ? ADDR_H : ADDR_L;
      ADDR_H:  slot_nxt = ADDR_L;
      ADDR_L:  slot_nxt = (rw_q == RW_RD) ? RESTART : DATA_W;
      CTRL_R:  slot_nxt = DATA_R;
      default: slot_nxt = STOP;
    endcase
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    scl_d      = scl_q;
    sda_out_d  = sda_out_q;
    sda_oe_d   = sda_oe_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    ack_d      = ack_q;
    done_d     = done_q;
    done_cnt_d = done_cnt_q;
    data_rd_d  = data_rd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rw_d       = rw_q;

    case (state_q)
      IDLE: begin
        scl_d      = 1'b1;
        sda_out_d  = 1'b1;
        sda_oe_d   = 1'b0;
        bit_cnt_d  = 4'd0;
        done_cnt_d = '0;
        if (start_rise && (bus.i2c_wr_flag || bus.i2c_rd_flag)) begin
          addr_d  = bus.i2c_addr;
          wdata_d = bus.i2c_data_wr;
          rw_d    = bus.i2c_wr_flag ? RW_WR : RW_RD;
          ack_d   = 1'b0;
          state_d = START;
        end
      end

      // SDA drops while SCL is high; the repeated start additionally has to
      // bring SDA high first because SCL is low on entry.
      START, RESTART: begin
        if (tick) begin
          case (phase)
            2'd0: begin
              sda_oe_d  = 1'b1;
              sda_out_d = 1'b1;
            end
            2'd1: scl_d = 1'b1;
            2'd2: sda_out_d = 1'b0;
            default: begin
              scl_d     = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = (state_q == START) ? CTRL_W : CTRL_R;
              shreg_d   = slot_byte(state_d, addr_q, wdata_q, shreg_q);
            end
          endcase
        end
      end

      CTRL_W, ADDR_H, ADDR_L, DATA_W, CTRL_R, DATA_R: begin
        if (tick) begin
          case (phase)
            2'd0: begin
              if (bit_cnt_q == ACK_SLOT) begin
                sda_oe_d  = is_rx;
                sda_out_d = 1'b1;
              end else begin
                sda_oe_d  = !is_rx;
                sda_out_d = shreg_q[7];
              end
            end
            2'd1: scl_d = 1'b1;
            2'd2: begin
              if (bit_cnt_q != ACK_SLOT) begin
                if (is_rx) shreg_d = {shreg_q[6:0], bus.sda_in};
              end else if (!is_rx && bus.sda_in) begin
                ack_d = 1'b1;
              end
            end
            default: begin
              scl_d = 1'b0;
              if (bit_cnt_q != ACK_SLOT) begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (!is_rx) shreg_d = {shreg_q[6:0], 1'b0};
              end else begin
                bit_cnt_d = 4'd0;
                state_d   = ack_q ? STOP : slot_nxt;
                shreg_d   = slot_byte(state_d, addr_q, wdata_q, shreg_q);
              end
            end
          endcase
        end
      end

      // SDA rises while SCL is high, then the line is released.
      STOP: begin
        if (tick) begin
          case (phase)
            2'd0: begin
              sda_oe_d  = 1'b1;
              sda_out_d = 1'b0;
            end
            2'd1: scl_d = 1'b1;
            2'd2: sda_out_d = 1'b1;
            default: begin
              sda_oe_d   = 1'b0;
              done_d     = 1'b1;
              done_cnt_d = '0;
              state_d    = DONE;
              if (rw_q == RW_RD) data_rd_d = shreg_q;
            end
          endcase
        end
      end

      DONE: begin
        if (done_cnt_q == DLST) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end else begin
          done_cnt_d = done_cnt_q + DCW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      scl_q      <= 1'b1;
      sda_out_q  <= 1'b1;
      sda_oe_q   <= 1'b0;
      bit_cnt_q  <= 4'd0;
      shreg_q    <= 8'h00;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      done_cnt_q <= '0;
      data_rd_q  <= 8'h00;
      addr_q     <= 16'h0000;
      wdata_q    <= 8'h00;
      rw_q       <= RW_WR;
      start_d1   <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_q      <= scl_d;
      sda_out_q  <= sda_out_d;
      sda_oe_q   <= sda_oe_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      done_cnt_q <= done_cnt_d;
      data_rd_q  <= data_rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rw_q       <= rw_d;
      start_d1   <= bus.i2c_start_flag;
    end
  end

  assign bus.scl         = scl_q;
  assign bus.sda_out     = sda_out_q;
  assign bus.sda_oe      = sda_oe_q;
  assign bus.i2c_done    = done_q;
  assign bus.i2c_ack     = ack_q;
  assign bus.i2c_data_rd = data_rd_q;

endmodule
